permute_emitter: RTL

PERMUTE_EMITTER -- requirements
Module: permute_emitter

---
 rtl/permute_emitter_pkg.sv | 20 ++
 rtl/permute_emitter_if.sv | 37 +++
 rtl/permute_emitter_perm_check.sv | 47 ++++
 rtl/permute_emitter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/permute_emitter_pkg.sv
// Shared types and constants for the permute emitter slice.
//   N_SLOTS    : number of map/source/output slots (4)
//   item_t     : one 2-bit source/output item
//   slot_idx_t : 2-bit slot index
//   state_t    : emitter FSM state encoding
package shapez_pkg;

    localparam int N_SLOTS = 4;

    typedef logic [1:0] item_t;
    typedef logic [1:0] slot_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        EMIT  = 2'd2,
        ERR   = 2'd3
    } state_t;

endpackage

// File: rtl/permute_emitter_if.sv
// Handshake bundle between upstream (map+source set), the emitter, and
// downstream (item stream).
//   master : the environment side; offers sets and consumes items
//   slave  : the emitter side
// Signals:
//   in_valid/in_ready             set handshake
//   mode                          0 = gather, 1 = scatter
//   map0..map3, src0..src3        slot map and source items
//   out_valid/out_ready           item handshake
//   out_data, out_idx, out_last   emitted item, slot number, final-slot flag
interface permute_emitter_if;
    import shapez_pkg::*;

    logic      in_valid;
    logic      in_ready;
    logic      mode;
    slot_idx_t map0, map1, map2, map3;
    item_t     src0, src1, src2, src3;
    logic      out_valid;
    logic      out_ready;
    item_t     out_data;
    slot_idx_t out_idx;
    logic      out_last;

    modport master (
        output in_valid, mode, map0, map1, map2, map3,
               src0, src1, src2, src3, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, mode, map0, map1, map2, map3,
               src0, src1, src2, src3, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/permute_emitter_perm_check.sv
// Combinational map analysis.
//   map0..map3   : slot index map
//   is_bijection : all four entries pairwise distinct
//   inv_map0..3  : inv_map[v] = j where map[j] == v (meaningful only when
//                  is_bijection is high; unmatched values read 0)
module perm_check
    import shapez_pkg::*;
(
    input  slot_idx_t map0,
    input  slot_idx_t map1,
    input  slot_idx_t map2,
    input  slot_idx_t map3,
    output logic      is_bijection,
    output slot_idx_t inv_map0,
    output slot_idx_t inv_map1,
    output slot_idx_t inv_map2,
    output slot_idx_t inv_map3
);

    slot_idx_t m   [N_SLOTS];
    slot_idx_t inv [N_SLOTS];

    always_comb begin
        m[0] = map0;
        m[1] = map1;
        m[2] = map2;
        m[3] = map3;

        is_bijection = (m[0] != m[1]) && (m[0] != m[2]) && (m[0] != m[3]) &&
                       (m[1] != m[2]) && (m[1] != m[3]) && (m[2] != m[3]);

        for (int v = 0; v < N_SLOTS; v++) begin
            inv[v] = '0;
            for (int j = 0; j < N_SLOTS; j++) begin
                if (m[j] == slot_idx_t'(v)) begin
                    inv[v] = slot_idx_t'(j);
                end
            end
        end
    end

    assign inv_map0 = inv[0];
    assign inv_map1 = inv[1];
    assign inv_map2 = inv[2];
    assign inv_map3 = inv[3];

endmodule

// File: rtl/permute_emitter.sv
// Permute emitter: accepts a 4-entry slot map plus 4 source items, checks
// the map is a permutation, then emits the 4 permuted items one per
// handshake. Gather: item(k) = src[map[k]]. Scatter: item(k) = src[j]
// with map[j] == k, using the inverse map computed during CHECK.
// A non-permutation map produces a one-cycle err pulse and bumps a
// saturating error counter instead of emitting.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : permute_emitter_if.slave (set in, item stream out)
//   err        : one-cycle pulse per rejected set
//   err_cnt    : saturating count of rejected sets
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a set (in_ready high once out of reset)
// CHECK | one cycle: test bijection, register inverse map, clear k
// EMIT  | drive item k; advance on out_ready, leave after slot 3
// ERR   | one cycle: err pulse, then back to IDLE
module permute_emitter
    import shapez_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    permute_emitter_if.slave     bus,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_t    state, state_nx;
    slot_idx_t k;
    logic      mode_r;
    slot_idx_t map_r [N_SLOTS];
    item_t     src_r [N_SLOTS];
    slot_idx_t inv_r [N_SLOTS];
    // Holds in_ready low while in reset and until the first edge after it.
    logic      armed;

    logic      is_bij;
    slot_idx_t inv_c0, inv_c1, inv_c2, inv_c3;
    logic      accept;

    perm_check u_perm_check (
        .map0         (map_r[0]),
        .map1         (map_r[1]),
        .map2         (map_r[2]),
        .map3         (map_r[3]),
        .is_bijection (is_bij),
        .inv_map0     (inv_c0),
        .inv_map1     (inv_c1),
        .inv_map2     (inv_c2),
        .inv_map3     (inv_c3)
    );

    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        err           = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = armed;
                if (bus.in_valid && armed) begin
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                state_nx = is_bij ? EMIT : ERR;
            end
            EMIT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready && (k == slot_idx_t'(N_SLOTS - 1))) begin
                    state_nx = IDLE;
                end
            end
            ERR: begin
                err      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Item outputs are forced to zero outside EMIT.
    always_comb begin
        bus.out_data = '0;
        bus.out_idx  = '0;
        bus.out_last = 1'b0;
        if (state == EMIT) begin
            bus.out_idx  = k;
            bus.out_last = (k == slot_idx_t'(N_SLOTS - 1));
            bus.out_data = mode_r ? src_r[inv_r[k]] : src_r[map_r[k]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed   <= 1'b0;
            k       <= '0;
            mode_r  <= 1'b0;
            err_cnt <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                map_r[i] <= '0;
                src_r[i] <= '0;
                inv_r[i] <= '0;
            end
        end else begin
            armed <= 1'b1;
            if (accept) begin
                mode_r   <= bus.mode;
                map_r[0] <= bus.map0;
                map_r[1] <= bus.map1;
                map_r[2] <= bus.map2;
                map_r[3] <= bus.map3;
                src_r[0] <= bus.src0;
                src_r[1] <= bus.src1;
                src_r[2] <= bus.src2;
                src_r[3] <= bus.src3;
            end
            if (state == CHECK) begin
                k        <= '0;
                inv_r[0] <= inv_c0;
                inv_r[1] <= inv_c1;
                inv_r[2] <= inv_c2;
                inv_r[3] <= inv_c3;
                if (!is_bij && (err_cnt != {ERR_CNT_W{1'b1}})) begin
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
                end
            end
            if ((state == EMIT) && bus.out_ready) begin
                k <= k + slot_idx_t'(1);
            end
        end
    end

endmodule
